// File: rtl/cic_pkg.sv
// Shared CIC definitions: sample type, rate constants and the output truncation helper.
package cic_pkg;

    localparam int unsigned CIC_MAX_DW    = 32'd64;
    localparam int unsigned CIC_DEFAULT_R = 32'd10;
    // Any rate at or below this value forwards every valid input.
    localparam int unsigned CIC_PASS_MAX  = 32'd1;

    typedef logic signed [CIC_MAX_DW-1:0] cic_sample_t;

    // Right-aligns the top out_dw bits of a data_dw-wide value held zero-extended in x.
    function automatic cic_sample_t cic_top_bits(input cic_sample_t x,
                                                 input int unsigned data_dw,
                                                 input int unsigned out_dw);
        return x >> (data_dw - out_dw);
    endfunction

endpackage

// File: rtl/cic_comb_decimator_if.sv
// Streaming bus of the CIC comb/decimator: sample input, rate input, filtered output.
interface cic_comb_decimator_if #(
    parameter int unsigned DATA_DW = 64,
    parameter int unsigned OUT_DW  = 32,
    parameter int unsigned RATE_DW = 32
);
    logic [DATA_DW-1:0] s_axis_in_tdata;
    logic               s_axis_in_tvalid;
    logic [RATE_DW-1:0] s_axis_rate_tdata;
    logic               s_axis_rate_tvalid;
    logic [OUT_DW-1:0]  m_axis_out_tdata;
    logic               m_axis_out_tvalid;

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid, s_axis_rate_tdata, s_axis_rate_tvalid,
        output m_axis_out_tdata, m_axis_out_tvalid
    );

    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid, s_axis_rate_tdata, s_axis_rate_tvalid,
        input  m_axis_out_tdata, m_axis_out_tvalid
    );
endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x delayed by M strobed samples, wrapping at DW bits.
module cic_comb_stage #(
    parameter int unsigned DW = 64,
    parameter int unsigned M  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);
    logic [DW-1:0] dly_r [M];
    logic [DW-1:0] diff_r;
    logic          valid_r;

    // Difference register and strobe-advanced delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                dly_r[i] <= '0;
            end
            diff_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                diff_r   <= in_data - dly_r[M-1];
                dly_r[0] <= in_data;
                for (int i = 1; i < M; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end else begin
                diff_r <= diff_r;
            end
        end
    end

    assign out_data  = diff_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC back end: rate-R downsampler, CIC_N comb stages and a truncating output register.
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int unsigned DATA_DW       = 64,
    parameter int unsigned OUT_DW        = 32,
    parameter int unsigned RATE_DW       = 32,
    parameter int unsigned CIC_R         = CIC_DEFAULT_R,
    parameter int unsigned CIC_N         = 7,
    parameter int unsigned CIC_M         = 1,
    parameter int unsigned VARIABLE_RATE = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cic_comb_decimator_if.slave  bus
);
    localparam logic [RATE_DW-1:0] RESET_RATE = RATE_DW'(CIC_R);
    localparam logic [RATE_DW-1:0] PASS_MAX   = RATE_DW'(CIC_PASS_MAX);

    logic [RATE_DW-1:0] rate_r;
    logic [RATE_DW-1:0] cnt_r;
    logic [DATA_DW-1:0] dec_data_r;
    logic               dec_valid_r;
    logic               rate_load_s;
    logic               last_s;

    logic [DATA_DW-1:0] comb_data_s [CIC_N+1];
    logic [CIC_N:0]     comb_valid_s;

    logic [OUT_DW-1:0]  out_data_r;
    logic               out_valid_r;

    // Rate-load qualification and end-of-decimation-window detection.
    always_comb begin
        rate_load_s = 1'b0;
        last_s      = 1'b0;
        if (VARIABLE_RATE != 32'd0) begin
            rate_load_s = bus.s_axis_rate_tvalid;
        end else begin
            rate_load_s = 1'b0;
        end
        if (rate_r <= PASS_MAX) begin
            last_s = 1'b1;
        end else begin
            last_s = (cnt_r == (rate_r - RATE_DW'(1)));
        end
    end

    // Downsampler: one counter for both modes; with a fixed rate rate_r never leaves CIC_R.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_r      <= RESET_RATE;
            cnt_r       <= '0;
            dec_data_r  <= '0;
            dec_valid_r <= 1'b0;
        end else if (rate_load_s) begin
            rate_r      <= bus.s_axis_rate_tdata;
            cnt_r       <= '0;
            dec_valid_r <= 1'b0;
        end else if (bus.s_axis_in_tvalid) begin
            if (last_s) begin
                dec_data_r  <= bus.s_axis_in_tdata;
                dec_valid_r <= 1'b1;
                cnt_r       <= '0;
            end else begin
                dec_valid_r <= 1'b0;
                cnt_r       <= cnt_r + RATE_DW'(1);
            end
        end else begin
            dec_valid_r <= 1'b0;
        end
    end

    assign comb_data_s[0]  = dec_data_r;
    assign comb_valid_s[0] = dec_valid_r;

    for (genvar j = 0; j < CIC_N; j++) begin : g_comb
        cic_comb_stage #(
            .DW (DATA_DW),
            .M  (CIC_M)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_data   (comb_data_s[j]),
            .in_valid  (comb_valid_s[j]),
            .out_data  (comb_data_s[j+1]),
            .out_valid (comb_valid_s[j+1])
        );
    end

    // Output register keeps the top OUT_DW bits of the last comb result and holds between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= comb_valid_s[CIC_N];
            if (comb_valid_s[CIC_N]) begin
                out_data_r <= OUT_DW'(cic_top_bits(cic_sample_t'(comb_data_s[CIC_N]), DATA_DW, OUT_DW));
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign bus.m_axis_out_tdata  = out_data_r;
    assign bus.m_axis_out_tvalid = out_valid_r;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Self-checking bench: fixed-rate, variable-rate and overflow-wrap instances against a scoreboard.
module tb_cic_comb_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [15:0] data; int cyc; } exp_t;
    typedef struct { int unsigned cnt; int unsigned rate; logic [15:0] prev; } mdl_t;
    typedef struct { logic [7:0] din; logic [3:0] dout; } wvec_t;

    exp_t        qa[$];
    exp_t        qv[$];
    exp_t        qw[$];
    logic [15:0] got_a[$];
    logic [15:0] last_a;
    logic [15:0] last_v;
    logic [3:0]  last_w;
    mdl_t        ma;
    mdl_t        mv;
    wvec_t       wtab[7];

    cic_comb_decimator_if #(.DATA_DW(16), .OUT_DW(16), .RATE_DW(32)) ia ();
    cic_comb_decimator_if #(.DATA_DW(16), .OUT_DW(16), .RATE_DW(32)) iv ();
    cic_comb_decimator_if #(.DATA_DW(8),  .OUT_DW(4),  .RATE_DW(32)) iw ();

    cic_comb_decimator #(.DATA_DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(4), .CIC_N(1),
                         .CIC_M(1), .VARIABLE_RATE(0))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    cic_comb_decimator #(.DATA_DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(4), .CIC_N(1),
                         .CIC_M(1), .VARIABLE_RATE(1))
        dut_v (.clk(clk), .reset_n(reset_n), .bus(iv));
    cic_comb_decimator #(.DATA_DW(8), .OUT_DW(4), .RATE_DW(32), .CIC_R(1), .CIC_N(2),
                         .CIC_M(2), .VARIABLE_RATE(0))
        dut_w (.clk(clk), .reset_n(reset_n), .bus(iw));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: strobe with data=%0h while no output was required (t=%0t)", name, act, $time);
    endtask

    // Reference N=1, M=1 decimator: returns 1 when this valid input completes a window.
    function automatic bit mdl_step(inout mdl_t m, input logic [15:0] d, output logic [15:0] e);
        int unsigned r;
        r = (m.rate <= 32'd1) ? 32'd1 : m.rate;
        e = d - m.prev;
        if (m.cnt == r - 32'd1) begin
            m.prev = d;
            m.cnt  = 32'd0;
            return 1'b1;
        end
        m.cnt = m.cnt + 32'd1;
        return 1'b0;
    endfunction

    task automatic drive_a(input logic v, input logic [15:0] d);
        logic [15:0] e;
        @(posedge clk); #1;
        ia.s_axis_in_tvalid = v;
        ia.s_axis_in_tdata  = d;
        if (v && mdl_step(ma, d, e)) qa.push_back('{e, cyc + 3});
    endtask

    task automatic drive_v(input logic v, input logic [15:0] d, input logic rv, input logic [31:0] rd);
        logic [15:0] e;
        @(posedge clk); #1;
        iv.s_axis_in_tvalid   = v;
        iv.s_axis_in_tdata    = d;
        iv.s_axis_rate_tvalid = rv;
        iv.s_axis_rate_tdata  = rd;
        if (rv) begin
            mv.rate = rd;
            mv.cnt  = 32'd0;
        end else if (v && mdl_step(mv, d, e)) begin
            qv.push_back('{e, cyc + 3});
        end
    endtask

    task automatic drive_w(input logic v, input logic [7:0] d, input logic [3:0] req);
        @(posedge clk); #1;
        iw.s_axis_in_tvalid = v;
        iw.s_axis_in_tdata  = d;
        if (v) qw.push_back('{16'(req), cyc + 4});
    endtask

    task automatic idle_all();
        ia.s_axis_in_tvalid = 1'b0;  ia.s_axis_in_tdata = 16'd0;
        ia.s_axis_rate_tvalid = 1'b0; ia.s_axis_rate_tdata = 32'd0;
        iv.s_axis_in_tvalid = 1'b0;  iv.s_axis_in_tdata = 16'd0;
        iv.s_axis_rate_tvalid = 1'b0; iv.s_axis_rate_tdata = 32'd0;
        iw.s_axis_in_tvalid = 1'b0;  iw.s_axis_in_tdata = 8'd0;
        iw.s_axis_rate_tvalid = 1'b0; iw.s_axis_rate_tdata = 32'd0;
    endtask

    // Asserts reset between clock edges and checks that outputs clear without waiting for a clock.
    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        reset_n = 1'b0;
        idle_all();
        #1;
        chk({tag, "_a_valid"}, 64'(ia.m_axis_out_tvalid), 64'd0);
        chk({tag, "_a_data"},  64'(ia.m_axis_out_tdata),  64'd0);
        chk({tag, "_v_valid"}, 64'(iv.m_axis_out_tvalid), 64'd0);
        chk({tag, "_v_data"},  64'(iv.m_axis_out_tdata),  64'd0);
        chk({tag, "_w_valid"}, 64'(iw.m_axis_out_tvalid), 64'd0);
        chk({tag, "_w_data"},  64'(iw.m_axis_out_tdata),  64'd0);
        qa.delete(); qv.delete(); qw.delete(); got_a.delete();
        ma = '{32'd0, 32'd4, 16'd0};
        mv = '{32'd0, 32'd4, 16'd0};
        last_a = 16'd0; last_v = 16'd0; last_w = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && (qa.size() + qv.size() + qw.size()) != 0; i++) @(posedge clk);
        repeat (2) @(negedge clk);
        chk({tag, "_drain_a"}, 64'(qa.size()), 64'd0);
        chk({tag, "_drain_v"}, 64'(qv.size()), 64'd0);
        chk({tag, "_drain_w"}, 64'(qw.size()), 64'd0);
    endtask

    task automatic chk_seq(input string name, input logic [15:0] want [4], input int n);
        chk({name, "_count"}, 64'(got_a.size()), 64'(n));
        for (int i = 0; i < n && i < got_a.size(); i++) chk(name, 64'(got_a[i]), 64'(want[i]));
        got_a.delete();
    endtask

    // Output monitors: every strobe must match the head of its scoreboard; tdata must hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (ia.m_axis_out_tvalid === 1'b1) begin
                got_a.push_back(ia.m_axis_out_tdata);
                if (qa.size() == 0) unexpected("a_strobe", 64'(ia.m_axis_out_tdata));
                else begin
                    e = qa.pop_front();
                    chk("a_data",  64'(ia.m_axis_out_tdata), 64'(e.data));
                    chk("a_cycle", 64'(cyc), 64'(e.cyc));
                end
                last_a = ia.m_axis_out_tdata;
            end else chk("a_hold", 64'(ia.m_axis_out_tdata), 64'(last_a));

            if (iv.m_axis_out_tvalid === 1'b1) begin
                if (qv.size() == 0) unexpected("v_strobe", 64'(iv.m_axis_out_tdata));
                else begin
                    e = qv.pop_front();
                    chk("v_data",  64'(iv.m_axis_out_tdata), 64'(e.data));
                    chk("v_cycle", 64'(cyc), 64'(e.cyc));
                end
                last_v = iv.m_axis_out_tdata;
            end else chk("v_hold", 64'(iv.m_axis_out_tdata), 64'(last_v));

            if (iw.m_axis_out_tvalid === 1'b1) begin
                if (qw.size() == 0) unexpected("w_strobe", 64'(iw.m_axis_out_tdata));
                else begin
                    e = qw.pop_front();
                    chk("w_data",  64'(iw.m_axis_out_tdata), 64'(e.data));
                    chk("w_cycle", 64'(cyc), 64'(e.cyc));
                end
                last_w = iw.m_axis_out_tdata;
            end else chk("w_hold", 64'(iw.m_axis_out_tdata), 64'(last_w));
        end
    end

    initial begin
        // 8-bit pass-through samples toggling 127/-128 through two M=2 combs; top nibble of the wrapped sum.
        wtab[0] = '{8'h7f, 4'h7};
        wtab[1] = '{8'h80, 4'h8};
        wtab[2] = '{8'h7f, 4'h8};
        wtab[3] = '{8'h80, 4'h8};
        wtab[4] = '{8'h7f, 4'h0};
        wtab[5] = '{8'h80, 4'h0};
        wtab[6] = '{8'h7f, 4'h0};

        reset_n = 1'b0;
        idle_all();
        ma = '{32'd0, 32'd4, 16'd0};
        mv = '{32'd0, 32'd4, 16'd0};
        last_a = 16'd0; last_v = 16'd0; last_w = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 64'(ia.m_axis_out_tvalid), 64'd0);
        chk("rst_a_data",  64'(ia.m_axis_out_tdata),  64'd0);
        chk("rst_w_valid", 64'(iw.m_axis_out_tvalid), 64'd0);
        chk("rst_w_data",  64'(iw.m_axis_out_tdata),  64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) drive_a(1'b1, 16'd5);
        drive_a(1'b0, 16'd0);
        drain("const");
        chk_seq("const_seq", '{16'd5, 16'd0, 16'd0, 16'd0}, 3);

        do_reset("r1");
        for (int i = 0; i < 16; i++) drive_a(1'b1, 16'(i));
        drive_a(1'b0, 16'd0);
        drain("ramp");
        chk_seq("ramp_seq", '{16'd3, 16'd4, 16'd4, 16'd4}, 4);

        do_reset("r2");
        for (int i = 0; i < 16; i++) begin
            drive_a(1'b1, 16'(i));
            drive_a(1'b0, 16'hdead);
        end
        drain("gap");
        chk_seq("gap_seq", '{16'd3, 16'd4, 16'd4, 16'd4}, 4);

        do_reset("r3");
        for (int i = 0; i < 6; i++) drive_v(1'b1, 16'(i), 1'b0, 32'd0);
        drive_v(1'b0, 16'd0, 1'b1, 32'd2);
        for (int i = 6; i < 14; i++) drive_v(1'b1, 16'(i), 1'b0, 32'd0);
        drive_v(1'b1, 16'd100, 1'b1, 32'd1);
        for (int i = 14; i < 20; i++) drive_v(1'b1, 16'(i), 1'b0, 32'd0);
        drive_v(1'b0, 16'd0, 1'b1, 32'd0);
        for (int i = 20; i < 24; i++) drive_v(1'b1, 16'(i * 3), 1'b0, 32'd0);
        drive_v(1'b0, 16'd0, 1'b1, 32'd3);
        for (int i = 0; i < 9; i++) drive_v(1'b1, 16'(16'hfff0 + i), 1'b0, 32'd0);
        drive_v(1'b0, 16'd0, 1'b0, 32'd0);
        drain("vrate");

        do_reset("r4");
        for (int i = 0; i < 7; i++) drive_w(1'b1, wtab[i].din, wtab[i].dout);
        drive_w(1'b0, 8'd0, 4'd0);
        drain("wrap");

        do_reset("r5");
        for (int i = 0; i < 10; i++) drive_a(1'b1, 16'(i));
        do_reset("mid");
        for (int i = 0; i < 3; i++) drive_a(1'b1, 16'(50 + i));
        drive_a(1'b0, 16'd0);
        repeat (6) @(posedge clk);
        chk_seq("mid_early", '{16'd0, 16'd0, 16'd0, 16'd0}, 0);
        drive_a(1'b1, 16'd53);
        drive_a(1'b0, 16'd0);
        drain("mid");
        chk_seq("mid_seq", '{16'd53, 16'd0, 16'd0, 16'd0}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
